// File: rtl/kyber_cbd.sv
// rtl/kyber_cbd.sv - centered-binomial sampler: PRF bytes to 256 signed coefficients, eta 2 or 3
module kyber_cbd #(
    parameter int N_COEF  = 256,
    parameter int BW_COEF = 3,
    parameter int N_BYTES = 192
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [8*N_BYTES-1:0]      i_ibytes,
    input  logic [1:0]                i_eta,
    output logic [N_COEF*BW_COEF-1:0] o_coeffs
);

    logic [N_COEF*BW_COEF-1:0] coeffs_next;

    // One independent slice per coefficient; both eta widths are computed and
    // the legal one selected, anything else collapses to zero.
    for (genvar k = 0; k < N_COEF; k++) begin : g_coef
        logic [1:0] a2;
        logic [1:0] b2;
        logic [1:0] a3;
        logic [1:0] b3;
        logic [2:0] d2;
        logic [2:0] d3;

        // eta = 2 consumes 4 stream bits per coefficient (bytes 0..127 only)
        assign a2 = {1'b0, i_ibytes[4*k]}   + {1'b0, i_ibytes[4*k+1]};
        assign b2 = {1'b0, i_ibytes[4*k+2]} + {1'b0, i_ibytes[4*k+3]};

        // eta = 3 consumes 6 stream bits per coefficient; sums never exceed 3
        assign a3 = {1'b0, i_ibytes[6*k]}   + {1'b0, i_ibytes[6*k+1]} + {1'b0, i_ibytes[6*k+2]};
        assign b3 = {1'b0, i_ibytes[6*k+3]} + {1'b0, i_ibytes[6*k+4]} + {1'b0, i_ibytes[6*k+5]};

        // Operands are 0..3, so a 3-bit wrap-around subtract is the exact
        // two's-complement difference in -3..+3.
        assign d2 = {1'b0, a2} - {1'b0, b2};
        assign d3 = {1'b0, a3} - {1'b0, b3};

        assign coeffs_next[BW_COEF*k +: BW_COEF] =
            (i_eta == 2'd2) ? d2 :
            (i_eta == 2'd3) ? d3 : 3'd0;
    end

    // Register the whole polynomial every cycle; reset clears it
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_coeffs <= '0;
        end else begin
            o_coeffs <= coeffs_next;
        end
    end

endmodule

// File: tb/tb_kyber_cbd.sv
// tb/tb_kyber_cbd.sv - scoreboard bench for kyber_cbd against a byte-level CBD model
module tb_kyber_cbd;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [1535:0] i_ibytes = '0;
    logic [1:0]    i_eta = 2'd0;
    logic [767:0]  o_coeffs;

    always #5 i_clk = ~i_clk;

    kyber_cbd dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_ibytes (i_ibytes),
        .i_eta    (i_eta),
        .o_coeffs (o_coeffs)
    );

    typedef struct {
        string        name;
        logic [767:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    byte unsigned mem [192];

    // Stream bit i is bit i%8 of byte i/8
    function automatic int bit_of(int i);
        return (int'(mem[i/8]) >> (i % 8)) & 1;
    endfunction

    // Reference: count ones in each half of a 2*eta bit group, subtract
    function automatic logic [767:0] ref_model(int eta);
        logic [767:0] r;
        r = '0;
        if (eta != 2 && eta != 3) return r;
        for (int k = 0; k < 256; k++) begin
            int a;
            int b;
            int c;
            a = 0;
            b = 0;
            for (int j = 0; j < eta; j++) begin
                a += bit_of(2*eta*k + j);
                b += bit_of(2*eta*k + eta + j);
            end
            c = a - b;
            r[3*k +: 3] = c[2:0];
        end
        return r;
    endfunction

    task automatic clr(input byte unsigned v);
        for (int n = 0; n < 192; n++) mem[n] = v;
    endtask

    task automatic rnd();
        for (int n = 0; n < 192; n++) mem[n] = 8'($urandom);
    endtask

    // Apply one vector at the falling edge and queue its expected result
    task automatic drive(input string name, input logic rst, input int eta);
        exp_t e;
        @(negedge i_clk);
        for (int n = 0; n < 192; n++) i_ibytes[8*n +: 8] = mem[n];
        i_rst = rst;
        i_eta = 2'(eta);
        e.name = name;
        e.exp  = rst ? '0 : ref_model(eta);
        sb.push_back(e);
    endtask

    // Monitor: every edge presents a result; compare it with the oldest expectation
    always @(posedge i_clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (o_coeffs !== e.exp) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", e.name, o_coeffs, e.exp);
            end
        end
    end

    initial begin
        rnd();
        drive("reset_eta3", 1'b1, 3);
        drive("reset_release", 1'b0, 3);

        clr(8'h00); mem[0] = 8'h03; drive("eta2_b0_03", 1'b0, 2);
        clr(8'h00); mem[0] = 8'h0C; drive("eta2_b0_0C", 1'b0, 2);
        clr(8'h00); mem[0] = 8'h50; drive("eta2_b0_50", 1'b0, 2);
        clr(8'h00); for (int n = 128; n < 192; n++) mem[n] = 8'hFF;
        drive("eta2_upper_ff", 1'b0, 2);
        clr(8'hFF); drive("eta2_all_ff", 1'b0, 2);

        clr(8'h00); mem[0] = 8'h07; drive("eta3_b0_07", 1'b0, 3);
        clr(8'h00); mem[0] = 8'h38; drive("eta3_b0_38", 1'b0, 3);
        clr(8'h00); mem[2] = 8'hFC; drive("eta3_b2_FC", 1'b0, 3);
        clr(8'h00); mem[191] = 8'hE0; drive("eta3_b191_E0", 1'b0, 3);

        rnd(); drive("illegal_eta0", 1'b0, 0);
        rnd(); drive("illegal_eta1", 1'b0, 1);
        rnd(); drive("eta2_rand_pre", 1'b0, 2);
        rnd(); drive("illegal_after_valid", 1'b0, 1);

        for (int i = 0; i < 64; i++) begin
            rnd();
            drive($sformatf("rand_%0d", i), 1'b0, ($urandom_range(0, 1) == 0) ? 2 : 3);
        end

        rnd(); drive("reset_mid", 1'b1, 2);
        rnd(); drive("after_reset_mid", 1'b0, 2);

        @(negedge i_clk);
        @(negedge i_clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
